// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART TX FIFO write port among NREQ byte streams.
// A stall watchdog drops the grant from a requester that goes quiet in the middle of a packet.
module uart_tx_arbiter #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TO_W    = 10,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DBIT-1:0]    req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         grant,
  output logic                    busy,
  output logic [DBIT-1:0]         w_data,
  output logic                    w_uart,
  input  logic                    tx_full,
  output logic                    timeout_err,
  output logic [$clog2(NREQ)-1:0] err_id
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam logic [TO_W-1:0] TimeoutVal = TO_W'(TIMEOUT);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [IW-1:0]   err_id_q, err_id_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  logic [NREQ-1:0] xfer_vec;
  logic            xfer;
  logic            owner_valid;
  logic            owner_last;
  logic            wd_hit;

  // Round-robin pick: lowest valid index above rr_q wins, otherwise lowest valid index overall.
  logic            found_hi, found_lo, pick_found;
  logic [IW-1:0]   cand_hi, cand_lo, pick_idx;

  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    cand_hi  = '0;
    cand_lo  = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (i > int'(rr_q)) begin
          found_hi = 1'b1;
          cand_hi  = IW'(i);
        end else begin
          found_lo = 1'b1;
          cand_lo  = IW'(i);
        end
      end
    end
    pick_found = found_hi | found_lo;
    pick_idx   = found_hi ? cand_hi : cand_lo;
  end

  // Datapath: zero-latency pass-through from the granted requester.
  assign req_ready   = grant_q & {NREQ{~tx_full}};
  assign xfer_vec    = req_valid & req_ready;
  assign xfer        = |xfer_vec;
  assign owner_valid = |(req_valid & grant_q);
  assign owner_last  = |(req_last & grant_q);
  assign w_uart      = xfer;

  always_comb begin
    w_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (xfer_vec[i]) begin
        w_data = req_data[i*DBIT +: DBIT];
      end
    end
  end

  // A transfer in the same cycle as the limit is reached counts as progress.
  assign wd_hit = (TIMEOUT != 0) && (cnt_q == TimeoutVal) && !xfer;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    err_id_d    = err_id_q;
    cnt_d       = cnt_q;
    timeout_err = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (pick_found) begin
          grant_d = NREQ'(1) << pick_idx;
          owner_d = pick_idx;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (xfer) begin
          cnt_d = '0;
          if (owner_last) begin
            grant_d = '0;
            rr_d    = owner_q;
            state_d = StIdle;
          end
        end else if (state_q == StBusy && wd_hit) begin
          timeout_err = 1'b1;
          err_id_d    = owner_q;
          rr_d        = owner_q;
          grant_d     = '0;
          cnt_d       = '0;
          state_d     = StIdle;
        end else if (!tx_full && !owner_valid) begin
          // Backpressure stalls are not the requester's fault and are not counted.
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_q     <= IW'(NREQ - 1);
      err_id_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      err_id_q <= err_id_d;
      cnt_q    <= cnt_d;
    end
  end

  assign grant  = grant_q;
  assign busy   = (state_q == StBusy);
  assign err_id = err_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, directed corner sequences and a random run
// checked against a cycle-level reference model of the arbitration rules.
module tb_uart_tx_arbiter;

  localparam int DBIT    = 8;
  localparam int NREQ    = 4;
  localparam int TO_W    = 10;
  localparam int TIMEOUT = 8;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DBIT-1:0] req_data;
  logic [NREQ-1:0]      req_last;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      grant;
  logic                 busy;
  logic [DBIT-1:0]      w_data;
  logic                 w_uart;
  logic                 tx_full;
  logic                 timeout_err;
  logic [1:0]           err_id;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .DBIT    (DBIT),
    .NREQ    (NREQ),
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .grant       (grant),
    .busy        (busy),
    .w_data      (w_data),
    .w_uart      (w_uart),
    .tx_full     (tx_full),
    .timeout_err (timeout_err),
    .err_id      (err_id)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        full;
    logic [3:0]  grant;
    logic [3:0]  ready;
    logic        wr;
    logic [7:0]  wdata;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  // Reference model state
  int         m_owner, m_rr, m_cnt, m_err;
  logic       m_busy, ew, et;
  logic [3:0] eg, er;
  logic [7:0] ed;
  logic [1:0] ee;
  logic [20:0] exp_v, act_v;
  int         npk;
  int         pv, pf;
  int         pv_tab[4] = '{90, 60, 25, 8};
  int         pf_tab[3] = '{0, 20, 60};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                       input logic f);
    req_valid = v;
    req_last  = l;
    req_data  = d;
    tx_full   = f;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    drive(4'b0, 4'b0, 32'h0, 1'b0);
    #3;
    reset_n = 1'b1;
    step();
    m_owner = -1;
    m_rr    = NREQ - 1;
    m_cnt   = 0;
    m_err   = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b1;
    drive(4'b0, 4'b0, 32'h0, 1'b0);

    // Requester 1 three-byte packet, then requesters 0 and 2 alternating 2-byte packets.
    vecs.push_back('{1'b1, 4'b0010, 4'b0000, 32'h0000_4100, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 4'b0010, 4'b0000, 32'h0000_4100, 1'b0, 4'b0010, 4'b0010, 1'b1, 8'h41, 1'b1});
    vecs.push_back('{1'b0, 4'b0010, 4'b0000, 32'h0000_4200, 1'b0, 4'b0010, 4'b0010, 1'b1, 8'h42, 1'b1});
    vecs.push_back('{1'b0, 4'b0010, 4'b0010, 32'h0000_4300, 1'b0, 4'b0010, 4'b0010, 1'b1, 8'h43, 1'b1});
    vecs.push_back('{1'b0, 4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 4'b0101, 4'b0000, 32'h00C0_00A0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 4'b0101, 4'b0000, 32'h00C0_00A0, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'hA0, 1'b1});
    vecs.push_back('{1'b0, 4'b0101, 4'b0001, 32'h00C0_00A1, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'hA1, 1'b1});
    vecs.push_back('{1'b0, 4'b0101, 4'b0000, 32'h00C0_00A2, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 4'b0101, 4'b0000, 32'h00C0_00A2, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'hC0, 1'b1});
    vecs.push_back('{1'b0, 4'b0101, 4'b0100, 32'h00C1_00A2, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'hC1, 1'b1});
    vecs.push_back('{1'b0, 4'b0101, 4'b0000, 32'h00C2_00A2, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 4'b0101, 4'b0000, 32'h00C2_00A2, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'hA2, 1'b1});
    vecs.push_back('{1'b0, 4'b0101, 4'b0001, 32'h00C2_00A3, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'hA3, 1'b1});
    vecs.push_back('{1'b0, 4'b0100, 4'b0000, 32'h00C2_0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 4'b0100, 4'b0000, 32'h00C2_0000, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'hC2, 1'b1});
    vecs.push_back('{1'b0, 4'b0100, 4'b0100, 32'h00C3_0000, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'hC3, 1'b1});
    vecs.push_back('{1'b0, 4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0});

    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        do_reset();
        chk($sformatf("vec%0d.err_id_reset", i), err_id, 2'd0);
      end
      drive(vecs[i].valid, vecs[i].last, vecs[i].data, vecs[i].full);
      @(negedge clk);
      chk($sformatf("vec%0d.grant", i), grant, vecs[i].grant);
      chk($sformatf("vec%0d.ready", i), req_ready, vecs[i].ready);
      chk($sformatf("vec%0d.w_uart", i), w_uart, vecs[i].wr);
      chk($sformatf("vec%0d.w_data", i), w_data, vecs[i].wdata);
      chk($sformatf("vec%0d.busy", i), busy, vecs[i].busy);
      chk($sformatf("vec%0d.timeout_err", i), timeout_err, 1'b0);
      step();
    end

    // Backpressure: requester 3 held through 20 full cycles, half of them with valid low.
    do_reset();
    drive(4'b1000, 4'b0000, 32'h3000_0000, 1'b0);
    @(negedge clk); chk("bp.idle", grant, 4'b0000); step();
    @(negedge clk); chk("bp.first", {grant, w_uart, w_data}, {4'b1000, 1'b1, 8'h30}); step();
    for (int i = 0; i < 20; i++) begin
      drive((i < 10) ? 4'b1000 : 4'b0000, 4'b0000, 32'h3100_0000, 1'b1);
      @(negedge clk);
      chk($sformatf("bp.hold%0d", i), {grant, req_ready, busy, w_uart, timeout_err},
          {4'b1000, 4'b0000, 1'b1, 1'b0, 1'b0});
      step();
    end
    drive(4'b1000, 4'b1000, 32'h3100_0000, 1'b0);
    @(negedge clk);
    chk("bp.resume", {w_uart, w_data, req_ready, timeout_err}, {1'b1, 8'h31, 4'b1000, 1'b0});
    step();
    drive(4'b0000, 4'b0000, 32'h0, 1'b0);
    @(negedge clk); chk("bp.end", {grant, busy}, {4'b0000, 1'b0}); step();

    // Watchdog: requester 0 stalls after one byte while requester 1 waits.
    do_reset();
    drive(4'b0011, 4'b0000, 32'h0000_6050, 1'b0);
    @(negedge clk); chk("to.idle0", grant, 4'b0000); step();
    @(negedge clk); chk("to.first", {grant, w_uart, w_data}, {4'b0001, 1'b1, 8'h50}); step();
    drive(4'b0010, 4'b0000, 32'h0000_6050, 1'b0);
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      chk($sformatf("to.stall%0d", i), {timeout_err, grant, w_uart}, {1'b0, 4'b0001, 1'b0});
      step();
    end
    @(negedge clk); chk("to.pulse", {timeout_err, grant}, {1'b1, 4'b0001}); step();
    @(negedge clk);
    chk("to.after", {timeout_err, grant, busy, err_id}, {1'b0, 4'b0000, 1'b0, 2'd0});
    step();
    drive(4'b0010, 4'b0010, 32'h0000_6050, 1'b0);
    @(negedge clk);
    chk("to.regrant", {grant, w_uart, w_data}, {4'b0010, 1'b1, 8'h60});
    step();
    // Requester 2: a transfer exactly at the limit is progress; the next full stall aborts.
    drive(4'b0100, 4'b0000, 32'h0070_0000, 1'b0);
    @(negedge clk); chk("pg.idle", grant, 4'b0000); step();
    @(negedge clk); chk("pg.first", {grant, w_data}, {4'b0100, 8'h70}); step();
    drive(4'b0000, 4'b0000, 32'h0070_0000, 1'b0);
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk); chk($sformatf("pg.stallA%0d", i), timeout_err, 1'b0); step();
    end
    drive(4'b0100, 4'b0000, 32'h0071_0000, 1'b0);
    @(negedge clk);
    chk("pg.progress", {timeout_err, w_uart, w_data, grant}, {1'b0, 1'b1, 8'h71, 4'b0100});
    step();
    drive(4'b0000, 4'b0000, 32'h0071_0000, 1'b0);
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk); chk($sformatf("pg.stallB%0d", i), timeout_err, 1'b0); step();
    end
    @(negedge clk); chk("pg.pulse", timeout_err, 1'b1); step();
    @(negedge clk); chk("pg.err_id", {err_id, grant, timeout_err}, {2'd2, 4'b0000, 1'b0}); step();

    // Asynchronous reset mid-packet, then all four contend with single-byte packets.
    drive(4'b0100, 4'b0000, 32'h0080_0000, 1'b0);
    @(negedge clk); step();
    @(negedge clk); chk("ar.granted", {grant, w_uart}, {4'b0100, 1'b1});
    #2 reset_n = 1'b0;
    #1 chk("ar.clear", {grant, busy, w_uart, req_ready, timeout_err, err_id}, 14'h0);
    step();
    chk("ar.held", {grant, busy, w_uart}, 6'h0);
    #1 reset_n = 1'b1;
    drive(4'b1111, 4'b1111, 32'hD3D2_D1D0, 1'b0);
    npk = 0;
    for (int c = 0; c < 100 && npk < 16; c++) begin
      @(negedge clk);
      if (w_uart === 1'b1) begin
        chk($sformatf("rr.pkt%0d", npk), {grant, w_data},
            {4'(1 << (npk % NREQ)), 8'(8'hD0 + npk % NREQ)});
        npk++;
      end
      step();
    end
    chk("rr.count", npk, 16);

    // Random stimulus against the reference model.
    do_reset();
    for (int blk = 0; blk < 12; blk++) begin
      pv = pv_tab[blk % 4];
      pf = pf_tab[blk % 3];
      for (int c = 0; c < 250; c++) begin
        for (int i = 0; i < NREQ; i++) begin
          req_valid[i] = ($urandom_range(99) < pv);
          req_last[i]  = ($urandom_range(99) < 35);
        end
        req_data = $urandom();
        tx_full  = ($urandom_range(99) < pf);
        @(negedge clk);
        m_busy = (m_owner >= 0);
        eg = m_busy ? 4'(1 << m_owner) : 4'b0;
        er = (m_busy && !tx_full) ? eg : 4'b0;
        ew = m_busy ? (!tx_full && req_valid[m_owner]) : 1'b0;
        ed = ew ? req_data[m_owner*DBIT +: DBIT] : 8'h00;
        et = m_busy && !ew && (m_cnt == TIMEOUT);
        ee = 2'(m_err);
        exp_v = {eg, er, m_busy, ew, ed, et, ee};
        act_v = {grant, req_ready, busy, w_uart, w_data, timeout_err, err_id};
        chk($sformatf("rand.b%0d.c%0d", blk, c), act_v, exp_v);
        if (!m_busy) begin
          m_cnt = 0;
          for (int k = 1; k <= NREQ; k++) begin
            if (m_owner < 0 && req_valid[(m_rr + k) % NREQ]) m_owner = (m_rr + k) % NREQ;
          end
        end else if (ew) begin
          m_cnt = 0;
          if (req_last[m_owner]) begin
            m_rr    = m_owner;
            m_owner = -1;
          end
        end else if (et) begin
          m_err   = m_owner;
          m_rr    = m_owner;
          m_owner = -1;
          m_cnt   = 0;
        end else if (!tx_full && !req_valid[m_owner]) begin
          m_cnt++;
        end
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
